uart_rx_fsm: RTL
================

// Module: uart_rx_fsm
// PURPOSE
//  Frame controller for the UART receiver. Tracks start/data/parity/stop bit timing
//  with an internal edge/bit counter. Drives enables to the data sampler, deserializer,
//  start/parity/stop checkers, and collects their error flags. Emits a one-cycle
//  data_valid per clean frame. Sits directly upstream of the parity/start/stop checkers.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (LSB first)
//  PRESC_W     6  width of prescale and edge_cnt; max oversampling 2^PRESC_W-1
// PORTS
//  clk          in   1           receiver clock
//  rst          in   1           asynchronous active-low reset
//  RX_IN        in   1           serial line, idle high
//  PAR_EN       in   1           1 = frame carries a parity bit
//  prescale     in   PRESC_W     oversampling ratio; legal 8/16/32
//  strt_glitch  in   1           start checker result, registered, valid cycle after strt_chk_en
//  par_err      in   1           parity checker result, registered, valid cycle after par_chk_en
//  stp_err      in   1           stop checker result, registered, valid cycle after stp_chk_en
//  dat_samp_en  out  1           sampler enable, high START..STOP
//  edge_cnt     out  PRESC_W     oversample index within current bit
//  bit_cnt      out  4           bit index in frame: 0=start, 1..DATA_WIDTH, then parity/stop
//  deser_en     out  1           1-cycle pulse: shift sampled_bit into deserializer
//  strt_chk_en  out  1           1-cycle pulse at last edge of start bit
//  par_chk_en   out  1           1-cycle pulse at last edge of parity bit
//  stp_chk_en   out  1           1-cycle pulse at last edge of stop bit
//  data_valid   out  1           1-cycle pulse: frame received without error
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): state IDLE; all outputs, counters, sticky error = 0.
//  - States: IDLE, START, DATA, PARITY, STOP, DONE. "last edge" = edge_cnt==prescale-1.
//  - edge_cnt increments each clk outside IDLE. At last edge, edge_cnt wraps to 0 and
//    bit_cnt increments. Both are cleared on entry to START from IDLE.
//  - IDLE: RX_IN==0 -> START. That cycle latches PAR_EN and prescale. Later mid-frame
//    changes to either are ignored.
//  - START: strt_chk_en pulses at last edge -> DATA. In the first DATA cycle, strt_glitch==1
//    aborts: -> IDLE, counters cleared, no data_valid.
//  - DATA: deser_en pulses at the last edge of each of the DATA_WIDTH bits.
//    After the last data bit: -> PARITY if PAR_EN is latched, else -> STOP.
//  - PARITY: par_chk_en pulses at last edge -> STOP.
//  - STOP: stp_chk_en pulses at last edge -> DONE.
//  - Sticky error: cleared on frame start. Set by par_err or stp_err seen in any cycle
//    from START through DONE.
//  - DONE lasts 1 cycle. data_valid = ~(sticky_err | stp_err). dat_samp_en = 0.
//    RX_IN==0 -> START with edge_cnt=1 (back-to-back frame; DONE cycle counts as edge 0).
//    Otherwise -> IDLE.
//  - Latency: start detected at cycle t0 (edge_cnt=0). data_valid occurs at
//    t0 + (2+DATA_WIDTH+PAR_EN)*prescale.
//  - Only one enable pulse is high in any cycle. Pulses never overlap data_valid.
// CONFIGURATION
//  UART_RX_ERR_FLAGS_EN defined:
//   - adds output err_flags[2:0] = {strt_glitch_seen, par_err_seen, stp_err_seen}.
//   - Updated in the DONE cycle, or on start-glitch abort. Held until next update; reset 0.
//   - Also adds a 1-cycle pulse frame_err that fires whenever a frame ends without data_valid.
//  UART_RX_ERR_FLAGS_EN undefined:
//   - Neither port exists. Errors only suppress data_valid.
// STRUCTURE
//  - Shared package uart_rx_pkg: state encoding localparams (IDLE..DONE),
//    legal prescale constants, and the DATA_WIDTH default.
//  - One sub-module, uart_rx_edge_bit_cnt: enable, load-1, clear, prescale in;
//    edge_cnt, bit_cnt, last_edge out.
//  - FSM, pulse decode and sticky error stay in uart_rx_fsm.
// TESTING  (DATA_WIDTH=8, prescale=8 unless noted)
//  1. PAR_EN=0, send 0xA5 with a clean stop bit -> 8 deser_en pulses, no par_chk_en;
//     data_valid is 1 cycle at t0+80.
//  2. PAR_EN=1, send 0x3C, par_err=1 one cycle after par_chk_en -> no data_valid
//     at t0+88; err_flags=3'b010 (ERR_FLAGS build).
//  3. RX_IN low for 2 cycles, strt_glitch=1 after strt_chk_en -> back to IDLE,
//     no deser_en, no data_valid.
//  4. Two frames back-to-back, RX_IN low in the DONE cycle -> second frame's data_valid
//     exactly 80 cycles after the first.
//  5. prescale=16, PAR_EN=1, stp_err=1 in the DONE cycle -> no data_valid;
//     frame_err pulse (ERR_FLAGS build).
//  6. Assert rst in the DATA state, bit_cnt=4 -> all outputs 0 immediately.
//     After release with RX_IN high, stays in IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART receiver frame controller.
//   - FSM state encoding (IDLE..DONE) as localparams plus the enum type built
//     on them.
//   - Legal oversampling ratios.
//   - Default frame data width and prescale/edge counter width.
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    // Frame shape defaults
    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESC_W_DEF    = 6;

    // Oversampling ratios the receiver is built to handle
    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // State encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// ----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
//   Oversample (edge) counter and bit counter for the UART frame controller.
//   edge_cnt runs 0..prescale-1 inside a bit; on the last edge it wraps to 0
//   and bit_cnt advances. Control priority: clr > load1 > en.
//
// Ports
//   clk        in   receiver clock
//   rst        in   asynchronous active-low reset
//   en         in   advance the counters this cycle
//   load1      in   restart a frame with edge_cnt=1, bit_cnt=0 (the current
//                   cycle already counts as edge 0 of the new start bit)
//   clr        in   clear both counters
//   prescale   in   oversampling ratio (already latched by the FSM)
//   edge_cnt   out  oversample index within the current bit
//   bit_cnt    out  bit index within the frame
//   last_edge  out  edge_cnt == prescale-1
// ----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load1,
    input  logic               clr,
    input  logic [PRESC_W-1:0] prescale,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               last_edge
);

    logic [PRESC_W-1:0] edge_next;
    logic [3:0]         bit_next;

    assign last_edge = (edge_cnt == (prescale - PRESC_W'(1)));

    always_comb begin
        edge_next = edge_cnt;
        bit_next  = bit_cnt;
        if (clr) begin
            edge_next = '0;
            bit_next  = '0;
        end else if (load1) begin
            edge_next = PRESC_W'(1);
            bit_next  = '0;
        end else if (en) begin
            if (last_edge) begin
                edge_next = '0;
                bit_next  = bit_cnt + 4'd1;
            end else begin
                edge_next = edge_cnt + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            edge_cnt <= edge_next;
            bit_cnt  <= bit_next;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// uart_rx_fsm
//   Frame controller for the UART receiver. Walks START, DATA, optional
//   PARITY and STOP bits using the edge/bit counter, emits one-cycle enables
//   to the sampler, deserializer and start/parity/stop checkers, collects the
//   checkers' error flags and pulses data_valid for each clean frame.
//
// Build option
//   UART_RX_ERR_FLAGS_EN  adds err_flags[2:0] = {strt_glitch, par_err, stp_err}
//                         seen in the last finished frame, and a frame_err
//                         pulse for every frame that ends without data_valid.
//
// Ports
//   clk          in   receiver clock
//   rst          in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   PAR_EN       in   frame carries a parity bit (latched at frame start)
//   prescale     in   oversampling ratio 8/16/32 (latched at frame start)
//   strt_glitch  in   start checker result, valid cycle after strt_chk_en
//   par_err      in   parity checker result, valid cycle after par_chk_en
//   stp_err      in   stop checker result, valid cycle after stp_chk_en
//   dat_samp_en  out  sampler enable, START..STOP
//   edge_cnt     out  oversample index within current bit
//   bit_cnt      out  bit index: 0=start, 1..DATA_WIDTH, then parity/stop
//   deser_en     out  pulse at last edge of each data bit
//   strt_chk_en  out  pulse at last edge of start bit
//   par_chk_en   out  pulse at last edge of parity bit
//   stp_chk_en   out  pulse at last edge of stop bit
//   data_valid   out  pulse in DONE when the frame had no error
//   err_flags    out  (option) error summary of last frame
//   frame_err    out  (option) pulse when a frame ends without data_valid
// ----------------------------------------------------------------------------
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    output logic [2:0]         err_flags,
    output logic               frame_err
`endif
);

    state_t             state_reg;
    state_t             state_next;

    // Frame configuration captured at frame start
    logic               par_en_reg;
    logic [PRESC_W-1:0] presc_reg;

    // Sticky error bits for the frame in flight
    logic               par_seen_reg;
    logic               par_seen_next;
    logic               stp_seen_reg;
    logic               stp_seen_next;

    logic               cnt_en;
    logic               cnt_load1;
    logic               cnt_clr;
    logic               last_edge;
    logic               glitch_abort;
    logic               frame_start;
    logic               in_done;

    // ------------------------------------------------------------------
    // Edge / bit counter
    // ------------------------------------------------------------------
    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (cnt_en),
        .load1     (cnt_load1),
        .clr       (cnt_clr),
        .prescale  (presc_reg),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        glitch_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!RX_IN) begin
                    state_next = START;
                end
            end
            START: begin
                if (last_edge) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // The start checker answers in the very first DATA cycle
                // (bit 1, edge 0); a glitch throws the whole frame away.
                if (bit_cnt == 4'd1 && edge_cnt == '0 && strt_glitch) begin
                    state_next   = IDLE;
                    glitch_abort = 1'b1;
                end else if (last_edge && bit_cnt == 4'(DATA_WIDTH)) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A low line here is the next start bit; this cycle is its edge 0.
                state_next = RX_IN ? IDLE : START;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_done     = (state_reg == DONE);
    assign frame_start = (state_next == START) &&
                         ((state_reg == IDLE) || (state_reg == DONE));

    // Counters sit at zero whenever the FSM is (or is about to be) idle.
    assign cnt_clr   = (state_reg == IDLE) || (state_next == IDLE);
    assign cnt_load1 = in_done && (state_next == START);
    assign cnt_en    = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Output decode; at most one enable is active since each belongs to
    // a different state, and data_valid only exists in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        case (state_reg)
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = last_edge;
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = last_edge && !glitch_abort;
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = last_edge;
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = last_edge;
            end
            DONE: begin
                // stp_err is only valid in this cycle, so it is folded in
                // directly rather than through the sticky bit.
                data_valid = !(par_seen_reg || stp_seen_reg || stp_err);
            end
            default: begin
                dat_samp_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky errors: cleared at frame start, accumulate START..DONE.
    // ------------------------------------------------------------------
    always_comb begin
        par_seen_next = par_seen_reg;
        stp_seen_next = stp_seen_reg;
        if (frame_start) begin
            par_seen_next = 1'b0;
            stp_seen_next = 1'b0;
        end else if (state_reg != IDLE) begin
            par_seen_next = par_seen_reg | par_err;
            stp_seen_next = stp_seen_reg | stp_err;
        end
    end

    // ------------------------------------------------------------------
    // State and frame-configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            par_en_reg   <= 1'b0;
            presc_reg    <= '0;
            par_seen_reg <= 1'b0;
            stp_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            par_seen_reg <= par_seen_next;
            stp_seen_reg <= stp_seen_next;
            // Configuration is frozen for the whole frame.
            if (frame_start) begin
                par_en_reg <= PAR_EN;
                presc_reg  <= prescale;
            end
        end
    end

`ifdef UART_RX_ERR_FLAGS_EN
    // ------------------------------------------------------------------
    // Error summary of the last finished frame.
    // ------------------------------------------------------------------
    logic [2:0] err_flags_reg;
    logic [2:0] err_flags_next;

    always_comb begin
        err_flags_next = err_flags_reg;
        if (glitch_abort) begin
            err_flags_next = {1'b1, par_seen_reg, stp_seen_reg};
        end else if (in_done) begin
            err_flags_next = {1'b0, par_seen_reg, stp_seen_reg | stp_err};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flags_reg <= 3'b000;
        end else begin
            err_flags_reg <= err_flags_next;
        end
    end

    assign err_flags = err_flags_reg;
    assign frame_err = glitch_abort || (in_done && !data_valid);
`endif

endmodule
